ov7670_grid_sampler: RTL and testbench

Parametrised OV7670 capture datapath and controller. It samples a GRIDxGRID lattice of RGB565 points from one camera frame and box-averages 2**LOG_WIN horizontally adjacent pixels per point. Results go into an internal register file.
Sits between the camera pins and the colour classifier. It replaces the fixed 3x3 single-pixel capture: sample coordinates are generic, pixels are properly byte-paired using HREF, and a start/done handshake with an error flag is provided.

---
 rtl/ov7670_pkg.sv | 31 +++
 rtl/ov7670_grid_sampler_if.sv | 26 ++
 rtl/edge_detector.sv | 28 ++
 rtl/ov7670_byte_pair.sv | 112 +++++++++++
 rtl/ov7670_grid_sampler.sv | 221 ++++++++++++++++++++++
 tb/tb_ov7670_grid_sampler.sv | 279 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 grid sampler: FSM states, RGB565 field
// layout and constant helpers for sample-window placement.
package ov7670_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam int R_LSB = 11;
  localparam int R_W   = 5;
  localparam int G_LSB = 5;
  localparam int G_W   = 6;
  localparam int B_LSB = 0;
  localparam int B_W   = 5;

  function automatic int win_lo(input int base, input int step, input int idx);
    return base + idx * step;
  endfunction

  function automatic int win_hi(input int base, input int step, input int idx, input int log_win);
    return base + idx * step + (1 << log_win) - 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ov7670_grid_sampler_if.sv
// Camera pins, capture handshake and grid readback port of the grid sampler.
interface ov7670_grid_sampler_if #(
  parameter int S_ADDR = 3
);
  logic              start;
  logic              VSYNC;
  logic              HREF;
  logic              PCLK;
  logic [7:0]        D;
  logic [S_ADDR-1:0] rd_line;
  logic [S_ADDR-1:0] rd_column;
  logic [15:0]       rd_pixel;
  logic              busy;
  logic              done;
  logic              frame_error;

  modport master (
    output start, VSYNC, HREF, PCLK, D, rd_line, rd_column,
    input  rd_pixel, busy, done, frame_error
  );

  modport slave (
    input  start, VSYNC, HREF, PCLK, D, rd_line, rd_column,
    output rd_pixel, busy, done, frame_error
  );
endinterface

// File: rtl/edge_detector.sv
// Registered rise/fall detector for an already-synchronised level.
module edge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);
  logic prev_r;
  logic rise_r;
  logic fall_r;

  // previous-level register and one-cycle edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      prev_r <= sig;
      rise_r <= sig & ~prev_r;
      fall_r <= ~sig & prev_r;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;
endmodule

// File: rtl/ov7670_byte_pair.sv
// Camera front end: synchronisers, edge detection, byte pairing into RGB565
// pixels and column/line position counters.
module ov7670_byte_pair
  import ov7670_pkg::*;
#(
  parameter int COLUMNS  = 320,
  parameter int LINES    = 240,
  parameter int S_LINE   = 8,
  parameter int S_COLUMN = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vsync,
  input  logic                href,
  input  logic                pclk,
  input  logic [7:0]          d,
  output logic                pix_valid,
  output logic [15:0]         pixel,
  output logic [S_COLUMN-1:0] column,
  output logic [S_LINE-1:0]   line,
  output logic                frame_start,
  output logic                frame_end
);
  localparam logic [S_COLUMN-1:0] COL_MAX  = S_COLUMN'(COLUMNS - 1);
  localparam logic [S_LINE-1:0]   LINE_MAX = S_LINE'(LINES - 1);

  logic [10:0]         sync1_r;
  logic [10:0]         sync2_r;
  logic [7:0]          d_dly_r;
  logic                href_dly_r;
  logic                pclk_rise_s;
  logic                pclk_fall_s;
  logic                href_rise_s;
  logic                href_fall_s;
  logic                phase_r;
  logic [7:0]          hi_r;
  logic [15:0]         pixel_r;
  logic                pix_valid_r;
  logic [S_COLUMN-1:0] column_r;
  logic [S_LINE-1:0]   line_r;
  logic                unused_edges_s;

  // two-flop synchronisers plus one extra stage on data/HREF so they line
  // up with the registered edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r    <= 11'd0;
      sync2_r    <= 11'd0;
      d_dly_r    <= 8'd0;
      href_dly_r <= 1'b0;
    end else begin
      sync1_r    <= {vsync, href, pclk, d};
      sync2_r    <= sync1_r;
      d_dly_r    <= sync2_r[7:0];
      href_dly_r <= sync2_r[9];
    end
  end

  edge_detector u_ed_vsync (.clk(clk), .rst_n(rst_n), .sig(sync2_r[10]), .rise(frame_end),   .fall(frame_start));
  edge_detector u_ed_href  (.clk(clk), .rst_n(rst_n), .sig(sync2_r[9]),  .rise(href_rise_s), .fall(href_fall_s));
  edge_detector u_ed_pclk  (.clk(clk), .rst_n(rst_n), .sig(sync2_r[8]),  .rise(pclk_rise_s), .fall(pclk_fall_s));

  assign unused_edges_s = href_rise_s ^ pclk_fall_s;

  // high byte first, low byte completes the pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r     <= 1'b0;
      hi_r        <= 8'd0;
      pixel_r     <= 16'd0;
      pix_valid_r <= 1'b0;
    end else begin
      pix_valid_r <= 1'b0;
      if (!href_dly_r) begin
        phase_r <= 1'b0;
      end else if (pclk_rise_s) begin
        if (!phase_r) begin
          hi_r    <= d_dly_r;
          phase_r <= 1'b1;
        end else begin
          pixel_r     <= {hi_r, d_dly_r};
          pix_valid_r <= 1'b1;
          phase_r     <= 1'b0;
        end
      end
    end
  end

  // column holds the index of the pixel currently flagged by pix_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      column_r <= '0;
      line_r   <= '0;
    end else begin
      if (href_fall_s) begin
        column_r <= '0;
      end else if (pix_valid_r && (column_r != COL_MAX)) begin
        column_r <= column_r + S_COLUMN'(1);
      end
      if (frame_start) begin
        line_r <= '0;
      end else if (href_fall_s && (line_r != LINE_MAX)) begin
        line_r <= line_r + S_LINE'(1);
      end
    end
  end

  assign pix_valid = pix_valid_r;
  assign pixel     = pixel_r;
  assign column    = column_r;
  assign line      = line_r;
endmodule

// File: rtl/ov7670_grid_sampler.sv
// Captures a GRID x GRID lattice of box-averaged RGB565 samples from one
// camera frame into a readable register file, with start/done handshake.
module ov7670_grid_sampler
  import ov7670_pkg::*;
#(
  parameter int COLUMNS  = 320,
  parameter int LINES    = 240,
  parameter int GRID     = 3,
  parameter int X0       = 40,
  parameter int XSTEP    = 100,
  parameter int Y0       = 40,
  parameter int YSTEP    = 80,
  parameter int LOG_WIN  = 2,
  parameter int S_LINE   = 8,
  parameter int S_COLUMN = 9,
  parameter int S_ADDR   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  ov7670_grid_sampler_if.slave  bus
);
  localparam int N     = GRID * GRID;
  localparam int IDX_W = idx_width(N);
  localparam int RA_W  = R_W + LOG_WIN;
  localparam int GA_W  = G_W + LOG_WIN;
  localparam int BA_W  = B_W + LOG_WIN;

  if ((GRID < 1) || (GRID > 8) || (GRID > (1 << S_ADDR)) || (LOG_WIN < 0) || (LOG_WIN > 3) ||
      (win_hi(X0, XSTEP, GRID - 1, LOG_WIN) >= COLUMNS) ||
      (win_lo(Y0, YSTEP, GRID - 1) >= LINES)) begin : g_bad_params
    $error("ov7670_grid_sampler: sample lattice does not fit the frame");
  end

  logic                pix_valid_s;
  logic [15:0]         pixel_s;
  logic [S_COLUMN-1:0] column_s;
  logic [S_LINE-1:0]   line_s;
  logic                frame_start_s;
  logic                frame_end_s;

  ov7670_byte_pair #(
    .COLUMNS (COLUMNS),
    .LINES   (LINES),
    .S_LINE  (S_LINE),
    .S_COLUMN(S_COLUMN)
  ) u_byte_pair (
    .clk        (clock),
    .rst_n      (reset),
    .vsync      (bus.VSYNC),
    .href       (bus.HREF),
    .pclk       (bus.PCLK),
    .d          (bus.D),
    .pix_valid  (pix_valid_s),
    .pixel      (pixel_s),
    .column     (column_s),
    .line       (line_s),
    .frame_start(frame_start_s),
    .frame_end  (frame_end_s)
  );

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic [N-1:0]      written_r;
  logic [15:0]       grid_r [N];
  logic [15:0]       rd_pixel_r;
  logic [RA_W-1:0]   acc_r_r;
  logic [GA_W-1:0]   acc_g_r;
  logic [BA_W-1:0]   acc_b_r;

  logic              row_hit_s;
  logic              col_hit_s;
  logic              col_first_s;
  logic              col_last_s;
  int                row_sel_s;
  int                col_sel_s;
  logic [IDX_W-1:0]  entry_s;
  logic              hit_s;
  logic              win_done_s;
  logic [RA_W-1:0]   sum_r_s;
  logic [GA_W-1:0]   sum_g_s;
  logic [BA_W-1:0]   sum_b_s;
  logic [15:0]       avg_s;
  logic              rd_valid_s;
  logic [IDX_W-1:0]  rd_entry_s;
  logic [15:0]       rd_data_s;

  // map the current pixel position onto the sample lattice
  always_comb begin
    row_hit_s   = 1'b0;
    col_hit_s   = 1'b0;
    col_first_s = 1'b0;
    col_last_s  = 1'b0;
    row_sel_s   = 0;
    col_sel_s   = 0;
    for (int i = 0; i < GRID; i++) begin
      row_hit_s = row_hit_s | (int'(line_s) == win_lo(Y0, YSTEP, i));
      row_sel_s = (int'(line_s) == win_lo(Y0, YSTEP, i)) ? i : row_sel_s;
    end
    for (int j = 0; j < GRID; j++) begin
      col_hit_s   = col_hit_s | ((int'(column_s) >= win_lo(X0, XSTEP, j)) &&
                                 (int'(column_s) <= win_hi(X0, XSTEP, j, LOG_WIN)));
      col_sel_s   = ((int'(column_s) >= win_lo(X0, XSTEP, j)) &&
                     (int'(column_s) <= win_hi(X0, XSTEP, j, LOG_WIN))) ? j : col_sel_s;
      col_first_s = col_first_s | (int'(column_s) == win_lo(X0, XSTEP, j));
      col_last_s  = col_last_s  | (int'(column_s) == win_hi(X0, XSTEP, j, LOG_WIN));
    end
    entry_s = IDX_W'(row_sel_s * GRID + col_sel_s);
  end

  assign hit_s      = pix_valid_s & row_hit_s & col_hit_s;
  assign win_done_s = hit_s & col_last_s;

  // the first pixel of a window restarts the sum instead of adding to it
  assign sum_r_s = (col_first_s ? RA_W'(0) : acc_r_r) + RA_W'(pixel_s[R_LSB +: R_W]);
  assign sum_g_s = (col_first_s ? GA_W'(0) : acc_g_r) + GA_W'(pixel_s[G_LSB +: G_W]);
  assign sum_b_s = (col_first_s ? BA_W'(0) : acc_b_r) + BA_W'(pixel_s[B_LSB +: B_W]);
  assign avg_s   = {sum_r_s[RA_W-1 -: R_W], sum_g_s[GA_W-1 -: G_W], sum_b_s[BA_W-1 -: B_W]};

  // window accumulators
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_r_r <= '0;
      acc_g_r <= '0;
      acc_b_r <= '0;
    end else if (hit_s) begin
      acc_r_r <= sum_r_s;
      acc_g_r <= sum_g_s;
      acc_b_r <= sum_b_s;
    end else begin
      acc_r_r <= acc_r_r;
      acc_g_r <= acc_g_r;
      acc_b_r <= acc_b_r;
    end
  end

  // capture controller with registered handshake outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      written_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r   <= ARM;
            busy_r    <= 1'b1;
            err_r     <= 1'b0;
            written_r <= '0;
          end
        end
        ARM: begin
          if (frame_start_s) begin
            state_r <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (win_done_s) begin
            written_r[entry_s] <= 1'b1;
          end
          if (frame_end_s) begin
            state_r <= FINISH;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            err_r   <= ~(&written_r);
          end
        end
        FINISH: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // grid register file: written only while capturing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        grid_r[k] <= 16'h0000;
      end
    end else if ((state_r == CAPTURE) && win_done_s) begin
      grid_r[entry_s] <= avg_s;
    end
  end

  // readback address decode; anything outside the lattice reads as zero
  always_comb begin
    rd_valid_s = (int'(bus.rd_line) < GRID) && (int'(bus.rd_column) < GRID);
    rd_entry_s = IDX_W'(int'(bus.rd_line) * GRID + int'(bus.rd_column));
    if (rd_valid_s) begin
      rd_data_s = grid_r[rd_entry_s];
    end else begin
      rd_data_s = 16'h0000;
    end
  end

  // registered readback
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_pixel_r <= 16'h0000;
    end else begin
      rd_pixel_r <= rd_data_s;
    end
  end

  assign bus.rd_pixel    = rd_pixel_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.frame_error = err_r;
endmodule

// File: tb/tb_ov7670_grid_sampler.sv
// Self-checking bench for ov7670_grid_sampler: camera frame generator plus a
// per-frame reference model of the sampled, box-averaged lattice.
module tb_ov7670_grid_sampler;
  localparam int COLUMNS = 16, LINES = 12, GRID = 3, X0 = 2, XSTEP = 5;
  localparam int Y0 = 1, YSTEP = 4, LOG_WIN = 1, S_LINE = 8, S_COLUMN = 9, S_ADDR = 3;
  localparam int WIN = 1 << LOG_WIN;
  localparam int N = GRID * GRID;

  typedef struct {
    int          rl;
    int          rc;
    logic [15:0] exp;
  } rd_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ov7670_grid_sampler_if #(.S_ADDR(S_ADDR)) bus();

  ov7670_grid_sampler #(
    .COLUMNS(COLUMNS), .LINES(LINES), .GRID(GRID), .X0(X0), .XSTEP(XSTEP),
    .Y0(Y0), .YSTEP(YSTEP), .LOG_WIN(LOG_WIN), .S_LINE(S_LINE),
    .S_COLUMN(S_COLUMN), .S_ADDR(S_ADDR)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [15:0] frame_px [LINES][COLUMNS];
  logic [15:0] exp_grid [N];
  rd_vec_t     tbl [12];

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cam_byte(input logic href, input logic [7:0] d);
    bus.HREF = href;
    bus.D    = d;
    bus.PCLK = 1'b0;
    tick(4);
    bus.PCLK = 1'b1;
    tick(4);
  endtask

  // frame of n_lines full lines from frame_px; returns right after VSYNC rises
  task automatic send_frame(input int n_lines);
    bus.VSYNC = 1'b1;
    repeat (3) cam_byte(1'b0, 8'h00);
    bus.VSYNC = 1'b0;
    repeat (3) cam_byte(1'b0, 8'h00);
    for (int y = 0; y < n_lines; y++) begin
      for (int x = 0; x < COLUMNS; x++) begin
        cam_byte(1'b1, frame_px[y][x][15:8]);
        cam_byte(1'b1, frame_px[y][x][7:0]);
      end
      repeat (3) cam_byte(1'b0, 8'h00);
    end
    bus.VSYNC = 1'b1;
  endtask

  task automatic random_frame();
    for (int y = 0; y < LINES; y++)
      for (int x = 0; x < COLUMNS; x++)
        frame_px[y][x] = 16'($urandom);
  endtask

  // averaged sample for each lattice point whose row arrived in the frame
  task automatic model_capture(input int n_lines, output logic exp_err);
    exp_err = 1'b0;
    for (int i = 0; i < GRID; i++) begin
      for (int j = 0; j < GRID; j++) begin
        int y, r, g, b;
        y = Y0 + i * YSTEP;
        if (y < n_lines) begin
          r = 0; g = 0; b = 0;
          for (int k = 0; k < WIN; k++) begin
            logic [15:0] p;
            p = frame_px[y][X0 + j * XSTEP + k];
            r += int'(p[15:11]);
            g += int'(p[10:5]);
            b += int'(p[4:0]);
          end
          exp_grid[i * GRID + j] = {5'(r / WIN), 6'(g / WIN), 5'(b / WIN)};
        end else begin
          exp_err = 1'b1;
        end
      end
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic read_entry(input int rl, input int rc, output logic [15:0] val);
    bus.rd_line   = S_ADDR'(rl);
    bus.rd_column = S_ADDR'(rc);
    tick(1);
    val = bus.rd_pixel;
  endtask

  task automatic check_grid(input string tag);
    logic [15:0] v;
    for (int e = 0; e < N; e++) begin
      read_entry(e / GRID, e % GRID, v);
      check($sformatf("%s_entry%0d", tag, e), 32'(v), 32'(exp_grid[e]));
    end
  endtask

  // bounded wait for done, then handshake checks
  task automatic finish_capture(input string tag, input logic exp_err, input int d0);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        check({tag, "_frame_error"}, 32'(bus.frame_error), 32'(exp_err));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    tick(20);
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    logic        exp_err;
    logic [15:0] v;
    int          d0;

    bus.start = 1'b0; bus.VSYNC = 1'b1; bus.HREF = 1'b0; bus.PCLK = 1'b0;
    bus.D = 8'h00; bus.rd_line = '0; bus.rd_column = '0;
    for (int e = 0; e < N; e++) exp_grid[e] = 16'h0000;

    // 1: reset, then reset again while armed
    tick(3);
    rst_n = 1'b1;
    tick(2);
    pulse_start();
    tick(2);
    check("t1_busy_armed", 32'(bus.busy), 32'd1);
    #3 rst_n = 1'b0;
    tick(1);
    check("t1_busy_in_reset", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick(2);
    check("t1_busy", 32'(bus.busy), 32'd0);
    check("t1_done", 32'(bus.done), 32'd0);
    check("t1_frame_error", 32'(bus.frame_error), 32'd0);
    check_grid("t1");

    // 2: constant frame, table-driven readback including out-of-range cells
    for (int y = 0; y < LINES; y++)
      for (int x = 0; x < COLUMNS; x++)
        frame_px[y][x] = 16'hF81F;
    for (int e = 0; e < N; e++) tbl[e] = '{e / GRID, e % GRID, 16'hF81F};
    tbl[9]  = '{3, 0, 16'h0000};
    tbl[10] = '{0, 3, 16'h0000};
    tbl[11] = '{7, 7, 16'h0000};
    d0 = done_cnt;
    pulse_start();
    model_capture(LINES, exp_err);
    send_frame(LINES);
    finish_capture("t2", 1'b0, d0);
    for (int t = 0; t < 12; t++) begin
      read_entry(tbl[t].rl, tbl[t].rc, v);
      check($sformatf("t2_rd_%0d_%0d", tbl[t].rl, tbl[t].rc), 32'(v), 32'(tbl[t].exp));
    end

    // 3: random frame with a known pair in window (1,1)
    random_frame();
    frame_px[5][7] = 16'h0841;
    frame_px[5][8] = 16'h1863;
    d0 = done_cnt;
    pulse_start();
    model_capture(LINES, exp_err);
    send_frame(LINES);
    finish_capture("t3", exp_err, d0);
    check_grid("t3");
    read_entry(1, 1, v);
    check("t3_pair_avg", 32'(v), 32'h1042);

    // 4: start arrives mid-frame, so the next frame is the captured one
    random_frame();
    d0 = done_cnt;
    fork
      send_frame(LINES);
      begin
        tick(100);
        pulse_start();
      end
    join
    tick(20);
    check("t4_busy_held", 32'(bus.busy), 32'd1);
    check("t4_no_done_skipped", 32'(done_cnt - d0), 32'd0);
    random_frame();
    model_capture(LINES, exp_err);
    send_frame(LINES);
    finish_capture("t4", exp_err, d0);
    check_grid("t4");

    // 5: frame cut after line 6, row 2 keeps the previous frame's values
    random_frame();
    d0 = done_cnt;
    pulse_start();
    model_capture(7, exp_err);
    send_frame(7);
    finish_capture("t5", exp_err, d0);
    check_grid("t5");

    // 6a: second start during capture is ignored
    random_frame();
    d0 = done_cnt;
    pulse_start();
    model_capture(LINES, exp_err);
    fork
      send_frame(LINES);
      begin
        tick(400);
        pulse_start();
        tick(2);
        check("t6_busy_after_restart", 32'(bus.busy), 32'd1);
      end
    join
    finish_capture("t6a", exp_err, d0);
    check_grid("t6a");

    // 6b: reset during capture clears everything and suppresses done
    random_frame();
    d0 = done_cnt;
    pulse_start();
    fork
      send_frame(LINES);
      begin
        tick(600);
        #2 rst_n = 1'b0;
        tick(3);
        check("t6b_busy_in_reset", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
      end
    join
    tick(40);
    for (int e = 0; e < N; e++) exp_grid[e] = 16'h0000;
    check("t6b_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6b_busy", 32'(bus.busy), 32'd0);
    check("t6b_frame_error", 32'(bus.frame_error), 32'd0);
    check_grid("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
